// File: rtl/inst_encoder.sv
// RV32I field-bundle to instruction-word encoder with a small output FIFO.
// Latency: a bundle accepted at edge N is visible on out_inst after edge N when the FIFO is empty.
// Backpressure: in_ready drops while the FIFO is full; a pop in the same cycle does not free room for an accept.
// Optional macro INST_ENC_ILLEGAL_DROP_EN: drop unsupported opcodes instead of pushing a NOP.
module inst_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             illegal_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] enc_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

`ifdef INST_ENC_ILLEGAL_DROP_EN
    localparam bit DROP_ILLEGAL = 1'b1;
`else
    localparam bit DROP_ILLEGAL = 1'b0;
`endif

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [31:0] enc_word;
    logic        legal;
    logic        is_bj;
    logic        accept;
    logic        push;
    logic        pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_inst  = mem[rd_ptr];

    assign accept = in_valid && in_ready;
    // Unsupported opcodes still occupy a slot (as a NOP) unless dropping is enabled.
    assign push   = accept && (legal || !DROP_ILLEGAL);
    assign pop    = out_valid && out_ready;

    // Pack the decoded fields into the instruction format selected by the opcode.
    always_comb begin
        enc_word = NOP_INST;
        legal    = 1'b1;
        is_bj    = 1'b0;
        case (in_opcode)
            OP_RTYPE: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            OP_ITYPE: begin
                // Shift-immediate forms carry funct7 above a 5-bit shamt.
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
            OP_LOAD, OP_JALR:
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            OP_STORE:
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            OP_BRANCH: begin
                is_bj    = 1'b1;
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
            end
            OP_LUI, OP_AUIPC:
                enc_word = {in_imm[31:12], in_rd, in_opcode};
            OP_JAL: begin
                is_bj    = 1'b1;
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            end
            default: begin
                legal    = 1'b0;
                enc_word = NOP_INST;
            end
        endcase
    end

    // FIFO storage, cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // One-cycle status pulses and the running count of pushed words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_o  <= 1'b0;
            misalign_o <= 1'b0;
            enc_count  <= '0;
        end else begin
            illegal_o  <= accept && !legal;
            misalign_o <= accept && is_bj && in_imm[0];
            if (push) enc_count <= enc_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder against a queue-based reference model.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Reference encoding is built from field shifts and masks on plain 32-bit integers.
module tb_inst_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        illegal_o;
    logic        misalign_o;
    logic [CNT_W-1:0] enc_count;

    inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .illegal_o(illegal_o), .misalign_o(misalign_o), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [31:0] q[$];
    logic [31:0] m_cnt = '0;
    logic        m_ill = 1'b0;
    logic        m_mis = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        case (op)
            7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] imm);
        logic [31:0] o, d, s1, s2, t3, t7;
        o = 32'(op); d = 32'(rd) << 7; s1 = 32'(rs1) << 15; s2 = 32'(rs2) << 20;
        t3 = 32'(f3) << 12; t7 = 32'(f7) << 25;
        case (op)
            7'h33: return t7 | s2 | s1 | t3 | d | o;
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) return t7 | ((imm & 32'h1F) << 20) | s1 | t3 | d | o;
                return ((imm & 32'hFFF) << 20) | s1 | t3 | d | o;
            end
            7'h03, 7'h67: return ((imm & 32'hFFF) << 20) | s1 | t3 | d | o;
            7'h23: return (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | t3 | ((imm & 32'h1F) << 7) | o;
            7'h63: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | t3
                          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | o;
            7'h37, 7'h17: return (imm & 32'hFFFFF000) | d | o;
            7'h6F: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                          | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
            default: return 32'h0000_0013;
        endcase
    endfunction

    // One clock cycle: predict from current inputs, advance, compare every output.
    task automatic cycle();
        bit acc, pp, lg;
        acc = in_valid && (q.size() != DEPTH);
        pp  = (q.size() != 0) && out_ready;
        lg  = is_legal(in_opcode);
        if (pp) void'(q.pop_front());
        m_ill = acc && !lg;
        m_mis = acc && (in_opcode == 7'h63 || in_opcode == 7'h6F) && in_imm[0];
        if (acc) begin
`ifdef INST_ENC_ILLEGAL_DROP_EN
            if (lg) begin q.push_back(ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm)); m_cnt++; end
`else
            q.push_back(ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
            m_cnt++;
`endif
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        if (q.size() != 0) check("out_inst", out_inst, q[0]);
        check("illegal_o", 32'(illegal_o), 32'(m_ill));
        check("misalign_o", 32'(misalign_o), 32'(m_mis));
        check("enc_count", enc_count, m_cnt);
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        in_valid = v; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // Send one bundle into an empty FIFO with the consumer ready; check the head word.
    task automatic send_one(input string tag, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp);
        out_ready = 1'b1;
        drive(1'b1, op, rd, rs1, rs2, f3, f7, imm);
        cycle();
        check(tag, out_inst, exp);
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        cycle();
    endtask

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_enc_count", enc_count, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_one("add", 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3);
        check("add_count", enc_count, 32'd1);
        send_one("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093);
        send_one("sw", 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423);
        send_one("lui", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7);
        send_one("beq", 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3);
        send_one("jal8", 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF);
        out_ready = 1'b1;
        drive(1'b1, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        cycle();
        check("jal9", out_inst, 32'h008000EF);
        check("jal9_misalign", 32'(misalign_o), 32'd1);
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        cycle();

        // Illegal opcode
        drive(1'b1, 7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        cycle();
        check("illegal_pulse", 32'(illegal_o), 32'd1);
`ifdef INST_ENC_ILLEGAL_DROP_EN
        check("illegal_drop_valid", 32'(out_valid), 32'd0);
        check("illegal_drop_count", enc_count, 32'd7);
`else
        check("illegal_nop", out_inst, 32'h00000013);
        check("illegal_nop_count", enc_count, 32'd8);
`endif
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        cycle();
        check("illegal_pulse_end", 32'(illegal_o), 32'd0);

        // Backpressure: 3 bundles with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 10));
            cycle();
            if (i == 1) check("bp_full", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_ready_back", 32'(in_ready), 32'd1);
        cycle();
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic with stability under stall
        for (int n = 0; n < 400; n++) begin
            if (!(in_valid && q.size() == DEPTH)) begin
                logic [6:0] op;
                op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
                drive(1'($urandom_range(0, 3) != 0), op, 5'($urandom), 5'($urandom), 5'($urandom),
                      3'($urandom), 7'($urandom), $urandom);
            end
            out_ready = 1'($urandom_range(0, 2) != 0);
            cycle();
        end

        // Reset mid-stream with two words buffered
        out_ready = 1'b0;
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        cycle(); cycle();
        drive(1'b1, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        while (q.size() != DEPTH) cycle();
        drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_count", enc_count, 32'd0);
        check("rst_mid_inst", out_inst, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete(); m_cnt = '0;
        check("rst_rel_ready", 32'(in_ready), 32'd1);
        cycle();
        check("rst_no_pulse", 32'({illegal_o, misalign_o}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RV32I instruction encoder: packs decoded fields (opcode, rd, rs1, rs2, funct3, funct7, immediate) into 32-bit instruction words.
- Inverse of the instruction-format structures used by the decode path.
- Feeds the instruction-memory loader and self-checking benches.
- Valid/ready on both sides; results buffered in a small output FIFO.

Parameters:
- DEPTH, 2, output FIFO entries; power of 2, >= 2.
- CNT_W, 32, width of the encoded-word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_opcode  in  7  opcode, per the opcode enumeration.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7.
- in_imm  in  32  immediate, unscaled byte value (U-type: full 32-bit value).
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts word.
- out_inst  out  32  encoded instruction (FIFO head).
- illegal_o  out  1  one-cycle pulse: accepted bundle had unsupported opcode.
- misalign_o  out  1  one-cycle pulse: B/J immediate with bit0 = 1.
- enc_count  out  CNT_W  words pushed since reset; wraps.

Behaviour:
- Reset values: in_ready = 1, out_valid = 0, out_inst = 0, illegal_o = 0, misalign_o = 0, enc_count = 0. FIFO pointers and count are cleared.
- Handshake:
  - Accept on in_valid && in_ready.
  - Pop on out_valid && out_ready.
  - in_ready = (count != DEPTH), combinational from the registered count. No accept when full, even if a pop occurs in the same cycle.
  - in_* must be held stable while in_valid && !in_ready.
  - out_inst is stable while out_valid && !out_ready.
- Encoding is combinational from the in_* fields, and the result is pushed on the accept edge. Latency: accept at edge N gives out_valid = 1 after edge N if the FIFO was empty.
- Formats:
  - OP_RTYPE: funct7 | rs2 | rs1 | f3 | rd | op.
  - OP_ITYPE, OP_LOAD, OP_JALR: imm[11:0] | rs1 | f3 | rd | op.
  - OP_ITYPE with f3 = 001 or 101: funct7 | imm[4:0] | rs1 | f3 | rd | op.
  - OP_STORE: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | op.
  - OP_BRANCH: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | op.
  - OP_LUI, OP_AUIPC: imm[31:12] | rd | op.
  - OP_JAL: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op.
- Out-of-range immediate bits are silently truncated.
- For B/J, imm[0] is dropped and misalign_o pulses the cycle after accept; the word is still pushed.
- Unsupported opcode: illegal_o pulses the cycle after accept; push behaviour is defined under Optional Feature.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged; both pointers advance and wrap modulo DEPTH.
- enc_count increments by 1 per push and wraps at 2^CNT_W.
- Reset asserted mid-operation: all buffered words are discarded immediately (asynchronous); no pulse outputs are generated.

Optional Feature:
- Macro: INST_ENC_ILLEGAL_DROP_EN.
- Defined: a bundle with an unsupported opcode is accepted but not pushed; enc_count is unchanged; illegal_o pulses.
- Undefined: a NOP 0x00000013 is pushed in its place; enc_count increments; illegal_o pulses.

Test Plan:
- R-type ADD: op 0110011, rd 3, rs1 1, rs2 2, f3 0, f7 0 -> out_inst 0x002081B3 one cycle after accept; enc_count = 1.
- I/S/U types:
  - ADDI x1,x0,5 -> 0x00500093.
  - SW x2,8(x1) -> 0x0020A423.
  - LUI x5, imm 0x12345000 -> 0x123452B7.
- Branch/jump:
  - BEQ x1,x2, imm -4 -> 0xFE208EE3.
  - JAL x1, imm 8 -> 0x008000EF.
  - JAL imm 9 -> 0x008000EF plus misalign_o pulse.
- Backpressure: hold out_ready = 0 and push 3 bundles -> in_ready = 0 after 2 accepts. Release out_ready -> words pop in order; in_ready returns to 1 the cycle after the first pop.
- Illegal opcode 0x7F -> illegal_o pulse. With INST_ENC_ILLEGAL_DROP_EN: no out_valid, enc_count unchanged. Without it: 0x00000013 output, enc_count + 1.
- Reset mid-stream: FIFO holding 2 words, assert rst_n = 0 -> out_valid = 0 and enc_count = 0 immediately. After release, in_ready = 1.
